// File: rtl/bram_pixel_reader.sv
// -----------------------------------------------------------------------------
// bram_pixel_reader
//
// Replays a stored image out of block RAM as an 8-bit pixel stream. Each
// 32-bit BRAM word holds four packed pixels; the reader fetches one word,
// waits the BRAM read latency, then unpacks the word one pixel per accepted
// beat on a valid/ready handshake. A final partial word emits only the
// pixels that belong to the image and drops the rest.
//
// Parameters
//   NUM_PIXELS  pixels per image (any value >= 1, not required to be a multiple of 4)
//   BASE_ADDR   byte address of the first image word
//   RD_LAT      BRAM read latency in cycles (1 or 2)
//
// Ports
//   clk           in   1   rising-edge clock
//   reset         in   1   synchronous, active-high reset
//   start         in   1   single-cycle pulse that begins one image (honoured only when idle)
//   bram_address  out  32  word-aligned byte address presented to the BRAM
//   bram_data     in   32  BRAM read data, valid RD_LAT cycles after the address
//   pixel_o       out  8   current pixel
//   pixel_valid   out  1   pixel_o holds a valid pixel
//   pixel_ready   in   1   consumer takes the pixel when pixel_valid && pixel_ready
//   busy          out  1   high from accepted start until image_done
//   image_done    out  1   single-cycle pulse once the last pixel has been taken
//
// Configuration
//   PIXEL_MSB_FIRST_EN  when defined, each word is unpacked starting from
//                       bits [31:24] (MSB-first packers); otherwise bits [7:0]
//                       come out first. Timing and counts are unaffected.
// -----------------------------------------------------------------------------
module bram_pixel_reader #(
    parameter int          NUM_PIXELS = 784,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          RD_LAT     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] bram_address,
    input  logic [31:0] bram_data,
    output logic [7:0]  pixel_o,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic        busy,
    output logic        image_done
);

    localparam int             PCW      = $clog2(NUM_PIXELS + 1);
    localparam logic [PCW-1:0] LAST_CNT = PCW'(NUM_PIXELS);
    localparam logic [1:0]     LAT_LAST = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EMIT,
        DONE
    } state_t;

    state_t         state_q;
    logic [31:0]    addr_q;
    logic [31:0]    word_q;
    logic [1:0]     idx_q;
    logic [1:0]     lat_q;
    logic [PCW-1:0] pix_cnt_q;
    logic [7:0]     pix_q;
    logic           valid_q;
    logic           busy_q;
    logic           done_q;

    logic [PCW-1:0] pix_cnt_d;
    logic [1:0]     idx_d;

    assign pix_cnt_d = pix_cnt_q + PCW'(1);
    assign idx_d     = idx_q + 2'd1;

    // Select stream position i (0 = first out) from a packed word.
    function automatic logic [7:0] unpack(input logic [31:0] w, input logic [1:0] i);
        logic [1:0] sel;
`ifdef PIXEL_MSB_FIRST_EN
        sel = ~i;
`else
        sel = i;
`endif
        return w[8*sel +: 8];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= BASE_ADDR;
            word_q    <= '0;
            idx_q     <= '0;
            lat_q     <= '0;
            pix_cnt_q <= '0;
            pix_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Address is registered on entry to FETCH so the BRAM
                        // sees it for the whole FETCH cycle.
                        addr_q    <= BASE_ADDR;
                        pix_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= FETCH;
                    end
                end

                FETCH: begin
                    lat_q   <= '0;
                    state_q <= WAIT;
                end

                WAIT: begin
                    if (lat_q == LAT_LAST) begin
                        word_q  <= bram_data;
                        idx_q   <= '0;
                        pix_q   <= unpack(bram_data, 2'd0);
                        valid_q <= 1'b1;
                        state_q <= EMIT;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end

                EMIT: begin
                    if (pixel_ready) begin
                        pix_cnt_q <= pix_cnt_d;
                        idx_q     <= idx_d;
                        if (pix_cnt_d == LAST_CNT) begin
                            // Also covers a partial last word: leftover bytes are dropped.
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (idx_q == 2'd3) begin
                            valid_q <= 1'b0;
                            addr_q  <= addr_q + 32'd4;
                            state_q <= FETCH;
                        end else begin
                            pix_q <= unpack(word_q, idx_d);
                        end
                    end
                end

                DONE: begin
                    // start is deliberately not looked at here.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bram_address = addr_q;
    assign pixel_o      = pix_q;
    assign pixel_valid  = valid_q;
    assign busy         = busy_q;
    assign image_done   = done_q;

endmodule
